alu_mc: RTL and testbench

//  Multi-cycle, parametrised successor to the single-cycle ALU.
//  - Adds a carry register, add/sub with carry, multi-bit shifts (logical/arith) and shift-add multiply.
//  - Operands enter via valid/ready; results leave via valid/ready with registered flags.
//  - Sits between the register-file read stage and write-back; the controller stalls on In_ready=0.

---
 rtl/alu_mc_pkg.sv | 50 +++++
 rtl/alu_mc_step.sv | 77 +++++++
 rtl/alu_mc.sv | 115 +++++++++++
 tb/tb_alu_mc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode and FSM state encodings,
// plus the mnemonic helper kept for the existing single-cycle ALU.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        ADC  = 4'd1,
        SUB  = 4'd2,
        SBC  = 4'd3,
        AND  = 4'd4,
        XOR  = 4'd5,
        OR   = 4'd6,
        LSH  = 4'd7,
        SHLN = 4'd8,
        SHRN = 4'd9,
        ASRN = 4'd10,
        MUL  = 4'd11,
        NOP  = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_mc_st_e;

    // Opcodes at or above this value decode as NOP.
    localparam int unsigned OP_CODES = 12;

    function automatic logic [31:0] op_mne(input logic [3:0] op);
        logic [31:0] m;
        case (op)
            4'd0:    m = "ADD ";
            4'd1:    m = "ADC ";
            4'd2:    m = "SUB ";
            4'd3:    m = "SBC ";
            4'd4:    m = "AND ";
            4'd5:    m = "XOR ";
            4'd6:    m = "OR  ";
            4'd7:    m = "LSH ";
            4'd8:    m = "SHLN";
            4'd9:    m = "SHRN";
            4'd10:   m = "ASRN";
            4'd11:   m = "MUL ";
            default: m = "NOP ";
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_mc_step.sv
// One iteration of the ALU datapath: add/sub, logic, 1-bit shift, or one
// shift-add multiply step on the 2W accumulator {hi, lo}.
module alu_mc_step
    import alu_mc_pkg::*;
#(
    parameter int W = 8
) (
    input  alu_op_e          op,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2*W-1:0]   acc,
    input  logic             carry_in,
    input  logic             sc_in,
    input  logic             shift_en,
    output logic [2*W-1:0]   nxt,
    output logic             carry_out
);
    localparam logic [W-1:0] ZW = '0;

    logic [W-1:0] lo, hi, b_sel;
    logic         cin;
    logic [W:0]   sum, mul_sum;

    assign lo      = acc[W-1:0];
    assign hi      = acc[2*W-1:W];
    assign b_sel   = (op == SUB || op == SBC) ? ~b : b;
    assign cin     = (op == ADD) ? 1'b0 : (op == SUB) ? 1'b1 : carry_in;
    assign sum     = {1'b0, a} + {1'b0, b_sel} + {ZW, cin};
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, a} : {(W+1){1'b0}});

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        nxt       = '0;
        carry_out = carry_in;
        case (op)
            ADD, ADC, SUB, SBC: begin
                nxt       = {ZW, sum[W-1:0]};
                carry_out = sum[W];
            end
            AND: begin nxt = {ZW, a & b}; carry_out = 1'b0; end
            XOR: begin nxt = {ZW, a ^ b}; carry_out = 1'b0; end
            OR:  begin nxt = {ZW, a | b}; carry_out = 1'b0; end
            LSH: begin
                nxt       = {ZW, a[W-2:0], sc_in};
                carry_out = a[W-1];
            end
            SHLN: begin
                nxt = {ZW, lo};
                if (shift_en) begin
                    nxt       = {ZW, lo[W-2:0], 1'b0};
                    carry_out = lo[W-1];
                end
            end
            SHRN: begin
                nxt = {ZW, lo};
                if (shift_en) begin
                    nxt       = {ZW, 1'b0, lo[W-1:1]};
                    carry_out = lo[0];
                end
            end
            ASRN: begin
                nxt = {ZW, lo};
                if (shift_en) begin
                    nxt       = {ZW, lo[W-1], lo[W-1:1]};
                    carry_out = lo[0];
                end
            end
            // Multiplier sits in lo and drains out the bottom as the product fills in.
            MUL: begin
                nxt       = {mul_sum, lo[W-1:1]};
                carry_out = |mul_sum[W:1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes: owns the FSM, iteration
// counter, operand/accumulator registers and the committed result/flags.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int W   = 8,
    parameter int Ops = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           In_valid,
    output logic           In_ready,
    input  logic [Ops-1:0] OP,
    input  logic [W-1:0]   InputA,
    input  logic [W-1:0]   InputB,
    input  logic           SC_in,
    output logic           Out_valid,
    input  logic           Out_ready,
    output logic [W-1:0]   Out,
    output logic [W-1:0]   OutHi,
    output logic           Carry,
    output logic           Zero,
    output logic           Parity,
    output logic           Odd
);
    localparam int SW = $clog2(W);
    localparam logic [1:0]   S_IDLE = IDLE;
    localparam logic [1:0]   S_EXEC = EXEC;
    localparam logic [1:0]   S_RESP = RESP;
    localparam logic [W-1:0] ZW     = '0;

    logic [1:0]     state_q;
    alu_op_e        op_q, op_dec;
    logic [W-1:0]   a_q, b_q;
    logic [2*W-1:0] acc_q, acc_nxt;
    logic [SW:0]    cnt_q, cnt_init;
    logic [SW-1:0]  amt;
    logic           sc_q, shift_en_q, carry_nxt, last;

    assign op_dec    = (OP >= Ops'(OP_CODES)) ? NOP : alu_op_e'(OP[3:0]);
    assign amt       = InputB[SW-1:0];
    assign last      = (cnt_q == (SW+1)'(1));
    assign In_ready  = (state_q == S_IDLE);
    assign Out_valid = (state_q == S_RESP);

    always_comb begin
        cnt_init = (SW+1)'(1);
        if (op_dec == MUL)
            cnt_init = (SW+1)'(W);
        else if ((op_dec == SHLN || op_dec == SHRN || op_dec == ASRN) && amt != '0)
            cnt_init = {1'b0, amt};
    end

    alu_mc_step #(.W(W)) u_step (
        .op        (op_q),
        .a         (a_q),
        .b         (b_q),
        .acc       (acc_q),
        .carry_in  (Carry),
        .sc_in     (sc_q),
        .shift_en  (shift_en_q),
        .nxt       (acc_nxt),
        .carry_out (carry_nxt)
    );

    // NOTE: the visible result and flags are separate registers written only on the
    // EXEC->RESP edge, so in-flight accumulator values never reach the outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            op_q       <= NOP;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sc_q       <= 1'b0;
            shift_en_q <= 1'b0;
            Out        <= '0;
            OutHi      <= '0;
            Carry      <= 1'b0;
            Zero       <= 1'b0;
            Parity     <= 1'b0;
            Odd        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (In_valid) begin
                    op_q       <= op_dec;
                    a_q        <= InputA;
                    b_q        <= InputB;
                    sc_q       <= SC_in;
                    shift_en_q <= (amt != '0);
                    cnt_q      <= cnt_init;
                    acc_q      <= {ZW, (op_dec == MUL) ? InputB : InputA};
                    state_q    <= S_EXEC;
                end
                S_EXEC: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    if (last) begin
                        Out     <= acc_nxt[W-1:0];
                        OutHi   <= acc_nxt[2*W-1:W];
                        Carry   <= carry_nxt;
                        Zero    <= ~|acc_nxt[W-1:0];
                        Parity  <= ^acc_nxt[W-1:0];
                        Odd     <= acc_nxt[0];
                        state_q <= S_RESP;
                    end
                end
                S_RESP: if (Out_ready) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (W=8): a behavioural model pushes expected
// results at issue time; they are popped and compared when Out_valid rises.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset, In_valid, Out_ready, SC_in;
    logic [3:0]   OP;
    logic [W-1:0] InputA, InputB;
    logic         In_ready, Out_valid, Carry, Zero, Parity, Odd;
    logic [W-1:0] Out, OutHi;

    typedef struct {
        string      tag;
        logic [7:0] out;
        logic [7:0] hi;
        logic       c, z, p, o;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_carry = 1'b0;

    alu_mc #(.W(W), .Ops(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .OP        (OP),
        .InputA    (InputA),
        .InputB    (InputB),
        .SC_in     (SC_in),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Out       (Out),
        .OutHi     (OutHi),
        .Carry     (Carry),
        .Zero      (Zero),
        .Parity    (Parity),
        .Odd       (Odd)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    function automatic exp_t model(input string tag, input int op, input int a,
                                   input int b, input bit sc, input bit cin);
        exp_t e;
        int   r   = 0;
        int   amt = b & 7;
        int   sa, p;
        e.tag = tag;
        e.hi  = 8'h00;
        e.c   = cin;
        e.lat = 2;
        case (op)
            0:  begin r = a + b;               e.c = (r > 255); end
            1:  begin r = a + b + int'(cin);   e.c = (r > 255); end
            2:  begin r = a + (255 - b) + 1;   e.c = (r > 255); end
            3:  begin r = a + (255 - b) + int'(cin); e.c = (r > 255); end
            4:  begin r = a & b; e.c = 1'b0; end
            5:  begin r = a ^ b; e.c = 1'b0; end
            6:  begin r = a | b; e.c = 1'b0; end
            7:  begin r = (a << 1) | int'(sc); e.c = ((a >> 7) & 1) != 0; end
            8:  begin
                r = a << amt;
                if (amt != 0) e.c = ((a >> (8 - amt)) & 1) != 0;
                e.lat = (amt == 0) ? 2 : amt + 1;
            end
            9:  begin
                r = a >> amt;
                if (amt != 0) e.c = ((a >> (amt - 1)) & 1) != 0;
                e.lat = (amt == 0) ? 2 : amt + 1;
            end
            10: begin
                sa = (a >= 128) ? a - 256 : a;
                r  = sa >>> amt;
                if (amt != 0) e.c = ((a >> (amt - 1)) & 1) != 0;
                e.lat = (amt == 0) ? 2 : amt + 1;
            end
            11: begin
                p     = a * b;
                r     = p;
                e.hi  = 8'((p >> 8) & 255);
                e.c   = (e.hi != 8'h00);
                e.lat = 9;
            end
            default: r = 0;
        endcase
        e.out = r[7:0];
        e.z   = (e.out == 8'h00);
        e.p   = ^e.out;
        e.o   = e.out[0];
        return e;
    endfunction

    task automatic run_op(input string tag, input int op, input int a, input int b,
                          input bit sc, input int hold);
        exp_t e, g;
        int   lat;
        @(negedge Clk);
        check({tag, "_in_ready"}, 32'(In_ready), 32'd1);
        Out_ready = (hold == 0);
        OP        = 4'(op);
        InputA    = 8'(a);
        InputB    = 8'(b);
        SC_in     = sc;
        In_valid  = 1'b1;
        e = model(tag, op, a, b, sc, m_carry);
        m_carry = e.c;
        sb.push_back(e);
        @(posedge Clk);
        lat = 1;
        #1 In_valid = 1'b0;
        while (!Out_valid && lat < 40) begin
            @(posedge Clk);
            lat++;
            #1;
        end
        g = sb.pop_front();
        if (!Out_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            Out_ready = 1'b1;
            return;
        end
        check({g.tag, "_out"},    32'(Out),    32'(g.out));
        check({g.tag, "_hi"},     32'(OutHi),  32'(g.hi));
        check({g.tag, "_carry"},  32'(Carry),  32'(g.c));
        check({g.tag, "_zero"},   32'(Zero),   32'(g.z));
        check({g.tag, "_parity"}, 32'(Parity), 32'(g.p));
        check({g.tag, "_odd"},    32'(Odd),    32'(g.o));
        check({g.tag, "_lat"},    32'(lat),    32'(g.lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            In_valid = (i == 1);
            OP       = 4'(ADD);
            InputA   = 8'h11;
            check({g.tag, "_hold_out"},   32'(Out),       32'(g.out));
            check({g.tag, "_hold_hi"},    32'(OutHi),     32'(g.hi));
            check({g.tag, "_hold_flags"}, 32'({Carry, Zero, Parity, Odd}),
                  32'({g.c, g.z, g.p, g.o}));
            check({g.tag, "_hold_valid"}, 32'(Out_valid), 32'd1);
            check({g.tag, "_hold_ready"}, 32'(In_ready),  32'd0);
        end
        @(negedge Clk);
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        @(posedge Clk);
        #1 check({g.tag, "_released"}, 32'(Out_valid), 32'd0);
    endtask

    initial begin
        Reset     = 1'b1;
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        SC_in     = 1'b0;
        OP        = 4'd0;
        InputA    = '0;
        InputB    = '0;
        #2 Reset  = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_outs",  32'({Out, OutHi}), 32'd0);
        check("rst_flags", 32'({Carry, Zero, Parity, Odd, Out_valid}), 32'd0);
        @(negedge Clk) Reset = 1'b1;
        @(posedge Clk);
        #1 check("rst_in_ready", 32'(In_ready), 32'd1);

        run_op("add_200_100", ADD, 200, 100, 1'b0, 0);
        run_op("adc_0_0",     ADC, 0,   0,   1'b0, 0);
        run_op("sub_5_5",     SUB, 5,   5,   1'b0, 0);
        run_op("sub_3_5",     SUB, 3,   5,   1'b0, 0);
        run_op("sbc_10_3",    SBC, 10,  3,   1'b0, 0);
        run_op("shrn_80_3",   SHRN, 8'h80, 3, 1'b0, 0);
        run_op("asrn_80_3",   ASRN, 8'h80, 3, 1'b0, 0);
        run_op("asrn_7f_7",   ASRN, 8'h7F, 7, 1'b0, 0);
        run_op("shln_c3_5",   SHLN, 8'hC3, 5, 1'b0, 0);
        run_op("shln_amt0",   SHLN, 8'hA5, 8, 1'b0, 0);
        run_op("lsh_sc1",     LSH, 8'h81, 0, 1'b1, 0);
        run_op("and",         AND, 8'hF0, 8'h3C, 1'b0, 0);
        run_op("xor",         XOR, 8'hAA, 8'h0F, 1'b0, 0);
        run_op("or",          OR,  8'h00, 8'h00, 1'b0, 0);
        run_op("mul_15_17",   MUL, 15,  17,  1'b0, 0);
        run_op("nop_12",      12,  8'h55, 8'h66, 1'b0, 0);
        run_op("mul_ff_ff",   MUL, 255, 255, 1'b0, 0);
        run_op("nop_15",      15,  8'h12, 8'h34, 1'b1, 0);
        run_op("hold_xor",    XOR, 8'h5A, 8'h33, 1'b0, 5);
        run_op("after_hold",  ADD, 8'h10, 8'h20, 1'b0, 0);

        for (int i = 0; i < 24; i++)
            run_op($sformatf("rnd%0d", i), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 0);

        // Abort a MUL mid-flight with reset, after leaving non-zero outputs behind.
        run_op("mul_pre_rst", MUL, 255, 255, 1'b0, 0);
        @(negedge Clk);
        OP       = 4'(MUL);
        InputA   = 8'hFF;
        InputB   = 8'hFF;
        In_valid = 1'b1;
        @(posedge Clk);
        #1 In_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        #1;
        check("abort_out",   32'(Out),       32'd0);
        check("abort_hi",    32'(OutHi),     32'd0);
        check("abort_carry", 32'(Carry),     32'd0);
        check("abort_flags", 32'({Zero, Parity, Odd}), 32'd0);
        check("abort_valid", 32'(Out_valid), 32'd0);
        @(negedge Clk) Reset = 1'b1;
        m_carry = 1'b0;
        run_op("add_1_1", ADD, 1, 1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
